// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI register file: FSM state encoding and
// frame-length helper.
package spi_regfile_pkg;

    // Legacy state encodings, kept so existing waveform decoders still apply.
    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_ADDR_ENC   = 2'd1;
    localparam logic [1:0] ST_DATA_ENC   = 2'd2;
    localparam logic [1:0] ST_COMMIT_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_ADDR   = ST_ADDR_ENC,
        ST_DATA   = ST_DATA_ENC,
        ST_COMMIT = ST_COMMIT_ENC
    } spi_state_e;

    // Total frame length: R/W bit, address field, data field.
    function automatic int unsigned frame_len(input int unsigned addr_w,
                                              input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_regfile_sync_edge.sv
// Two-flop synchroniser with rising/falling edge detection on the
// synchronised level.
module spi_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain plus one delay stage for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regfile.sv
// SPI (mode 0) peripheral exposing NUM_REGS registers of DATA_W bits.
// Frame: R/W bit, ADDR_W address bits, DATA_W data bits, MSB first.
// Optional read-back path: define SPI_REGFILE_READBACK_EN.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         SCLK,
    input  logic                         COPI,
    input  logic                         nCS,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int unsigned F     = frame_len(ADDR_W, DATA_W);
    localparam int unsigned CNT_W = $clog2(F + 2);
    localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(F);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(F + 1);
    localparam logic [ADDR_W:0]  NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    logic unused_sclk_lvl;
    logic sclk_rise, sclk_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic copi_meta_q, copi_sync_q;

    spi_sync_edge u_sclk_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (SCLK),
        .q_o    (unused_sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge u_ncs_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (nCS),
        .q_o    (ncs_lvl),
        .rise_o (ncs_rise),
        .fall_o (ncs_fall)
    );

    // COPI only needs the level; same depth as SCLK keeps them aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            copi_meta_q <= 1'b0;
            copi_sync_q <= 1'b0;
        end else begin
            copi_meta_q <= COPI;
            copi_sync_q <= copi_meta_q;
        end
    end

    spi_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [F-1:0]         rx_q, rx_d;
    logic [DATA_W-1:0]    regs_q [NUM_REGS];

    logic                 sample;
    logic                 commit_wr, commit_err, read_ok;
    logic                 frame_full, rx_rw, addr_ok;
    logic [ADDR_W-1:0]    rx_addr;
    logic [DATA_W-1:0]    rx_data;

    assign sample     = sclk_rise & ~ncs_lvl;
    assign frame_full = (cnt_q == CNT_FULL);
    assign rx_rw      = rx_q[F-1];
    assign rx_addr    = rx_q[DATA_W +: ADDR_W];
    assign rx_data    = rx_q[DATA_W-1:0];
    assign addr_ok    = ({1'b0, rx_addr} < NUM_REGS_W);

`ifdef SPI_REGFILE_READBACK_EN
    assign read_ok = frame_full & ~rx_rw;
`else
    assign read_ok = 1'b0;
`endif

    // Frame FSM: bit collection, counter saturation and commit decision.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        commit_wr  = 1'b0;
        commit_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                    rx_d    = '0;
                end
            end
            ST_ADDR: begin
                if (ncs_rise) begin
                    state_d    = ST_IDLE;
                    commit_err = 1'b1;
                end else if (sample) begin
                    rx_d  = {rx_q[F-2:0], copi_sync_q};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_HDR) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (ncs_rise) begin
                    state_d = ST_COMMIT;
                end else if (sample) begin
                    rx_d = {rx_q[F-2:0], copi_sync_q};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                commit_wr  = frame_full & rx_rw & addr_ok;
                commit_err = ~(frame_full & rx_rw & addr_ok) & ~read_ok;
            end
        endcase
    end

    // State, counter and receive shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
        end
    end

    // Register array and write/error pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= commit_wr;
            frame_err <= commit_err;
            if (commit_wr) begin
                wr_addr <= rx_addr;
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    if (rx_addr == ADDR_W'(k)) begin
                        regs_q[k] <= rx_data;
                    end
                end
            end
        end
    end

    // Flatten the register array onto the output bus.
    always_comb begin
        regs_out = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            regs_out[k*DATA_W +: DATA_W] = regs_q[k];
        end
    end

`ifdef SPI_REGFILE_READBACK_EN
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rd_data;
    logic              is_read_q;
    logic              fall_seen_q;
    logic              hdr_done;
    logic [ADDR_W-1:0] hdr_addr;

    assign hdr_done = (state_q == ST_ADDR) && (state_d == ST_DATA);
    assign hdr_addr = rx_d[ADDR_W-1:0];

    // Read mux; addresses past the array fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (hdr_addr == ADDR_W'(k)) begin
                rd_data = regs_q[k];
            end
        end
    end

    // The first SCLK fall after the header only presents the MSB; later
    // falls advance the shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q        <= '0;
            is_read_q   <= 1'b0;
            fall_seen_q <= 1'b0;
        end else if (hdr_done) begin
            tx_q        <= rd_data;
            is_read_q   <= ~rx_d[ADDR_W];
            fall_seen_q <= 1'b0;
        end else if ((state_q == ST_DATA) && sclk_fall && !ncs_lvl) begin
            if (fall_seen_q) begin
                tx_q <= {tx_q[DATA_W-2:0], 1'b0};
            end
            fall_seen_q <= 1'b1;
        end
    end

    assign cipo_oe = (state_q == ST_DATA) && is_read_q;
    assign CIPO    = cipo_oe & tx_q[DATA_W-1];
`else
    logic unused_sclk_fall;
    assign unused_sclk_fall = sclk_fall;
    assign cipo_oe = 1'b0;
    assign CIPO    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Self-checking bench for spi_regfile: default geometry instance plus a
// 16-bit-data instance. Write/error events are scoreboarded per instance.
module tb_spi_regfile;

    localparam int HALF = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic SCLK = 1'b0;
    logic COPI = 1'b0;
    logic ncs0 = 1'b1;
    logic ncs1 = 1'b1;

    logic         cipo0, oe0, strobe0, err0;
    logic [39:0]  regs0;
    logic [6:0]   waddr0;
    logic         cipo1, oe1, strobe1, err1;
    logic [255:0] regs1;
    logic [3:0]   waddr1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          err;
        logic [7:0]  addr;
        logic [15:0] data;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    ev_t ev0, ev1;

    logic [7:0]  exp0 [5];
    logic [15:0] exp1 [16];

    always #5 clk = ~clk;

    spi_regfile u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (SCLK),
        .COPI      (COPI),
        .nCS       (ncs0),
        .CIPO      (cipo0),
        .cipo_oe   (oe0),
        .regs_out  (regs0),
        .wr_strobe (strobe0),
        .wr_addr   (waddr0),
        .frame_err (err0)
    );

    spi_regfile #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (SCLK),
        .COPI      (COPI),
        .nCS       (ncs1),
        .CIPO      (cipo1),
        .cipo_oe   (oe1),
        .regs_out  (regs1),
        .wr_strobe (strobe1),
        .wr_addr   (waddr1),
        .frame_err (err1)
    );

    function automatic logic [39:0] flat0();
        logic [39:0] r = '0;
        for (int k = 0; k < 5; k++) r[k*8 +: 8] = exp0[k];
        return r;
    endfunction

    function automatic logic [255:0] flat1();
        logic [255:0] r = '0;
        for (int k = 0; k < 16; k++) r[k*16 +: 16] = exp1[k];
        return r;
    endfunction

    // Scoreboard for instance 0: every strobe/err cycle consumes one event.
    always @(negedge clk) begin
        if (!rst && (strobe0 === 1'b1 || err0 === 1'b1)) begin
            n_vec++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL event0: got strobe=%0b err=%0b, required no event", strobe0, err0);
            end else begin
                ev0 = q0.pop_front();
                if (err0 !== ev0.err || strobe0 !== !ev0.err) begin
                    n_err++;
                    $display("FAIL event0_kind: got strobe=%0b err=%0b, required err=%0b", strobe0, err0, ev0.err);
                end else if (!ev0.err && (waddr0 !== ev0.addr[6:0] || regs0[ev0.addr*8 +: 8] !== ev0.data[7:0])) begin
                    n_err++;
                    $display("FAIL event0_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             waddr0, regs0[ev0.addr*8 +: 8], ev0.addr, ev0.data[7:0]);
                end
            end
        end
    end

    // Scoreboard for the wide instance.
    always @(negedge clk) begin
        if (!rst && (strobe1 === 1'b1 || err1 === 1'b1)) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL event1: got strobe=%0b err=%0b, required no event", strobe1, err1);
            end else begin
                ev1 = q1.pop_front();
                if (err1 !== ev1.err || strobe1 !== !ev1.err) begin
                    n_err++;
                    $display("FAIL event1_kind: got strobe=%0b err=%0b, required err=%0b", strobe1, err1, ev1.err);
                end else if (!ev1.err && (waddr1 !== ev1.addr[3:0] || regs1[ev1.addr*16 +: 16] !== ev1.data)) begin
                    n_err++;
                    $display("FAIL event1_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             waddr1, regs1[ev1.addr*16 +: 16], ev1.addr, ev1.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Mode-0 controller; CIPO/cipo_oe of instance 0 sampled just before each rise.
    task automatic spi_xfer(input bit inst, input logic [31:0] frame, input int nbits,
                            input int rst_at, output logic [31:0] miso, output logic [31:0] oe);
        miso = '0;
        oe   = '0;
        if (inst) ncs1 = 1'b0; else ncs0 = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            COPI = frame[nbits-1-i];
            #(HALF);
            miso[nbits-1-i] = cipo0;
            oe[nbits-1-i]   = oe0;
            SCLK = 1'b1;
            #(HALF);
            SCLK = 1'b0;
        end
        #(HALF);
        ncs0 = 1'b1;
        ncs1 = 1'b1;
        COPI = 1'b0;
        #(HALF);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) exp0[k] = '0;
        for (int k = 0; k < 16; k++) exp1[k] = '0;
        n_vec++; if (regs0 !== 40'h0) begin n_err++; $display("FAIL reset_regs0: got %h, required 0", regs0); end
        n_vec++; if (regs1 !== 256'h0) begin n_err++; $display("FAIL reset_regs1: got %h, required 0", regs1); end
        n_vec++; if (strobe0 !== 1'b0 || err0 !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got strobe=%b err=%b, required 0 0", strobe0, err0); end
        n_vec++; if (waddr0 !== 7'h0) begin n_err++; $display("FAIL reset_waddr: got %h, required 0", waddr0); end
        n_vec++; if (cipo0 !== 1'b0 || oe0 !== 1'b0) begin n_err++; $display("FAIL reset_cipo: got cipo=%b oe=%b, required 0 0", cipo0, oe0); end
    endtask

    task automatic test_write();
        logic [31:0] m, o;
        q0.push_back('{err: 1'b0, addr: 8'd2, data: 16'h55});
        exp0[2] = 8'h55;
        spi_xfer(1'b0, 32'h8255, 16, -1, m, o);
        repeat (10) @(negedge clk);
        n_vec++; if (q0.size() != 0) begin n_err++; $display("FAIL write_event: got %0d pending, required 0", q0.size()); end
        n_vec++; if (regs0 !== flat0()) begin n_err++; $display("FAIL write_regs: got %h, required %h", regs0, flat0()); end
        n_vec++; if (waddr0 !== 7'd2) begin n_err++; $display("FAIL write_waddr: got %h, required 2", waddr0); end
    endtask

    task automatic test_bad_addr();
        logic [31:0] m, o;
        q0.push_back('{err: 1'b1, addr: 8'd0, data: 16'h0});
        spi_xfer(1'b0, 32'h85AA, 16, -1, m, o);
        repeat (10) @(negedge clk);
        n_vec++; if (q0.size() != 0) begin n_err++; $display("FAIL badaddr_event: got %0d pending, required 0", q0.size()); end
        n_vec++; if (regs0 !== flat0()) begin n_err++; $display("FAIL badaddr_regs: got %h, required %h", regs0, flat0()); end
    endtask

    task automatic test_bad_length();
        logic [31:0] m, o;
        q0.push_back('{err: 1'b1, addr: 8'd0, data: 16'h0});
        spi_xfer(1'b0, 32'h4133, 15, -1, m, o);
        q0.push_back('{err: 1'b1, addr: 8'd0, data: 16'h0});
        spi_xfer(1'b0, 32'h10266, 17, -1, m, o);
        repeat (10) @(negedge clk);
        n_vec++; if (q0.size() != 0) begin n_err++; $display("FAIL length_event: got %0d pending, required 0", q0.size()); end
        n_vec++; if (regs0 !== flat0()) begin n_err++; $display("FAIL length_regs: got %h, required %h", regs0, flat0()); end
    endtask

    task automatic test_read();
        logic [31:0] m, o;
        q0.push_back('{err: 1'b0, addr: 8'd1, data: 16'hA5});
        exp0[1] = 8'hA5;
        spi_xfer(1'b0, 32'h81A5, 16, -1, m, o);
`ifndef SPI_REGFILE_READBACK_EN
        q0.push_back('{err: 1'b1, addr: 8'd0, data: 16'h0});
`endif
        spi_xfer(1'b0, 32'h0100, 16, -1, m, o);
        repeat (10) @(negedge clk);
        n_vec++; if (q0.size() != 0) begin n_err++; $display("FAIL read_event: got %0d pending, required 0", q0.size()); end
        n_vec++; if (regs0 !== flat0()) begin n_err++; $display("FAIL read_regs: got %h, required %h", regs0, flat0()); end
`ifdef SPI_REGFILE_READBACK_EN
        n_vec++; if (m[7:0] !== 8'hA5) begin n_err++; $display("FAIL read_cipo: got %h, required a5", m[7:0]); end
        n_vec++; if (o[15:0] !== 16'h00FF) begin n_err++; $display("FAIL read_oe: got %h, required 00ff", o[15:0]); end
`else
        n_vec++; if (m[15:0] !== 16'h0 || o[15:0] !== 16'h0) begin n_err++; $display("FAIL read_tied: got cipo=%h oe=%h, required 0 0", m[15:0], o[15:0]); end
`endif
        n_vec++; if (oe0 !== 1'b0 || cipo0 !== 1'b0) begin n_err++; $display("FAIL read_idle: got cipo=%b oe=%b, required 0 0", cipo0, oe0); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] m, o;
        spi_xfer(1'b0, 32'h83FF, 16, 9, m, o);
        for (int k = 0; k < 5; k++) exp0[k] = '0;
        for (int k = 0; k < 16; k++) exp1[k] = '0;
        repeat (10) @(negedge clk);
        n_vec++; if (regs0 !== 40'h0) begin n_err++; $display("FAIL rstmid_regs: got %h, required 0", regs0); end
        q0.push_back('{err: 1'b0, addr: 8'd3, data: 16'h77});
        exp0[3] = 8'h77;
        spi_xfer(1'b0, 32'h8377, 16, -1, m, o);
        repeat (10) @(negedge clk);
        n_vec++; if (q0.size() != 0) begin n_err++; $display("FAIL rstmid_event: got %0d pending, required 0", q0.size()); end
        n_vec++; if (regs0 !== flat0()) begin n_err++; $display("FAIL rstmid_regs2: got %h, required %h", regs0, flat0()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] m, o;
        q0.push_back('{err: 1'b0, addr: 8'd0, data: 16'h11});
        exp0[0] = 8'h11;
        spi_xfer(1'b0, 32'h8011, 16, -1, m, o);
        q0.push_back('{err: 1'b0, addr: 8'd4, data: 16'h44});
        exp0[4] = 8'h44;
        spi_xfer(1'b0, 32'h8444, 16, -1, m, o);
        repeat (10) @(negedge clk);
        n_vec++; if (q0.size() != 0) begin n_err++; $display("FAIL b2b_event: got %0d pending, required 0", q0.size()); end
        n_vec++; if (regs0 !== flat0()) begin n_err++; $display("FAIL b2b_regs: got %h, required %h", regs0, flat0()); end
        n_vec++; if (waddr0 !== 7'd4) begin n_err++; $display("FAIL b2b_waddr: got %h, required 4", waddr0); end
    endtask

    task automatic test_wide();
        logic [31:0] m, o;
        q1.push_back('{err: 1'b0, addr: 8'd15, data: 16'hBEEF});
        exp1[15] = 16'hBEEF;
        spi_xfer(1'b1, 32'h1FBEEF, 21, -1, m, o);
        repeat (10) @(negedge clk);
        n_vec++; if (q1.size() != 0) begin n_err++; $display("FAIL wide_event: got %0d pending, required 0", q1.size()); end
        n_vec++; if (regs1 !== flat1()) begin n_err++; $display("FAIL wide_regs: got %h, required %h", regs1, flat1()); end
        n_vec++; if (regs1[255:240] !== 16'hBEEF) begin n_err++; $display("FAIL wide_top: got %h, required beef", regs1[255:240]); end
        n_vec++; if (q0.size() != 0 || regs0 !== flat0()) begin n_err++; $display("FAIL wide_isolation: got %h, required %h", regs0, flat0()); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bad_addr();
        test_bad_length();
        test_read();
        test_back_to_back();
        test_reset_midframe();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
